// File: rtl/text_cell_fill.sv
// text_cell_fill: 128x48 character-cell buffer for the XGA text layer.
// An FSM fills the buffer with pseudo-random printable codes or clears it to
// spaces, one cell per clock. A two-stage pixel read pipeline serves the glyph
// renderer. Optional macro TEXT_CELL_BOOT_CLEAR_EN: when defined, a clear runs
// automatically on reset release.
module text_cell_fill #(
  parameter int unsigned width     = 1024,
  parameter int unsigned height    = 768,
  parameter int unsigned glyph_w   = 8,
  parameter int unsigned glyph_h   = 16,
  parameter logic [15:0] lfsr_seed = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fill,
  input  logic       clear,
  input  logic [9:0] x_pixel,
  input  logic [9:0] y_pixel,
  output logic [7:0] char_code,
  output logic [3:0] glyph_row,
  output logic [2:0] glyph_col,
  output logic       busy,
  output logic       done
);

  localparam int unsigned COLS  = width / glyph_w;
  localparam int unsigned ROWS  = height / glyph_h;
  localparam int unsigned CELLS = COLS * ROWS;
  localparam int unsigned AW    = $clog2(CELLS);
  localparam int unsigned GCB   = $clog2(glyph_w);
  localparam int unsigned GRB   = $clog2(glyph_h);
  localparam int unsigned CXB   = $clog2(COLS);
  localparam logic [AW-1:0] LAST = AW'(CELLS - 1);

`ifdef TEXT_CELL_BOOT_CLEAR_EN
  localparam logic BOOT_CLEAR = 1'b1;
`else
  localparam logic BOOT_CLEAR = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, FILL, CLEAR} state_t;

  state_t          state_q, state_d;
  logic            start;
  logic            boot_pend;
  logic [AW-1:0]   cnt_q;
  logic [15:0]     lfsr_q;
  logic            we;
  logic [7:0]      wdata;
  logic            last_p1;

  logic [7:0]      mem [CELLS];
  logic [7:0]      ram_q_p2;
  logic [AW-1:0]   rd_addr;
  logic            oor;
  logic [AW-1:0]   addr_p1;
  logic            oor_p1, oor_p2;
  logic [3:0]      row_p1, row_p2;
  logic [2:0]      col_p1, col_p2;

  // Printable fill code: low seven LFSR bits forced into 0x20..0x7F.
  function automatic logic [7:0] fill_char(input logic [15:0] s);
    return {1'b0, s[6:0]} | 8'h20;
  endfunction

  // Galois right-shift LFSR step, taps 0xB400.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // Next-state, request acceptance and write-port drive.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    we      = 1'b0;
    wdata   = 8'h20;
    case (state_q)
      IDLE: begin
        if (clear || boot_pend) begin
          state_d = CLEAR;
          start   = 1'b1;
        end else if (fill) begin
          state_d = FILL;
          start   = 1'b1;
        end
      end
      FILL: begin
        we    = 1'b1;
        wdata = fill_char(lfsr_q);
        if (cnt_q == LAST) state_d = IDLE;
      end
      CLEAR: begin
        we = 1'b1;
        if (cnt_q == LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state: FSM, cell counter, LFSR and the busy/done status pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      boot_pend <= BOOT_CLEAR;
      cnt_q     <= '0;
      lfsr_q    <= lfsr_seed;
      busy      <= 1'b0;
      last_p1   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) boot_pend <= 1'b0;
      if (start) cnt_q <= '0;
      else if (we) cnt_q <= cnt_q + 1'b1;
      if (start && state_d == FILL) lfsr_q <= lfsr_seed;
      else if (state_q == FILL) lfsr_q <= lfsr_next(lfsr_q);
      busy    <= (state_q != IDLE);
      last_p1 <= we && (cnt_q == LAST);
      done    <= last_p1;
    end
  end

  assign rd_addr = AW'({y_pixel[9:GRB], x_pixel[GCB +: CXB]});
  assign oor     = (32'(y_pixel) >= height) || (32'(x_pixel) >= width);

  // Stage 1 boundary: read address (clamped when off-screen).
  always_ff @(posedge clk) begin
    addr_p1 <= oor ? '0 : rd_addr;
  end

  // Stage 1/2 boundaries: glyph position and off-screen flag travel with the read.
  always_ff @(posedge clk) begin
    if (reset) begin
      oor_p1 <= 1'b1;
      row_p1 <= '0;
      col_p1 <= '0;
      oor_p2 <= 1'b1;
      row_p2 <= '0;
      col_p2 <= '0;
    end else begin
      oor_p1 <= oor;
      row_p1 <= 4'(y_pixel[GRB-1:0]);
      col_p1 <= 3'(x_pixel[GCB-1:0]);
      oor_p2 <= oor_p1;
      row_p2 <= row_p1;
      col_p2 <= col_p1;
    end
  end

  // Stage 2 boundary: simple dual-port RAM, registered read returns old data on collision.
  always_ff @(posedge clk) begin
    if (we) mem[cnt_q] <= wdata;
    ram_q_p2 <= mem[addr_p1];
  end

  assign char_code = oor_p2 ? 8'h20 : ram_q_p2;
  assign glyph_row = row_p2;
  assign glyph_col = col_p2;

endmodule

// File: tb/tb_text_cell_fill.sv
// Directed bench for text_cell_fill: clear, fill golden values, read alignment,
// request arbitration and reset during a fill.
module tb_text_cell_fill;

  localparam int CELLS = 6144;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fill = 1'b0;
  logic       clear = 1'b0;
  logic [9:0] x_pixel = '0;
  logic [9:0] y_pixel = '0;
  logic [7:0] char_code;
  logic [3:0] glyph_row;
  logic [2:0] glyph_col;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_fill [CELLS];

  text_cell_fill dut (
    .clk(clk), .reset(reset), .fill(fill), .clear(clear),
    .x_pixel(x_pixel), .y_pixel(y_pixel),
    .char_code(char_code), .glyph_row(glyph_row), .glyph_col(glyph_col),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic pulse(input logic f, input logic c);
    fill  = f;
    clear = c;
    @(posedge clk); #1;
    fill  = 1'b0;
    clear = 1'b0;
  endtask

  // Observe a full operation; optionally pulse fill at sample index inject_k.
  task automatic run_op(input int inject_k, output int busy_n, output int done_n, output int done_k);
    busy_n = 0;
    done_n = 0;
    done_k = -1;
    for (int k = 0; k < 6300; k++) begin
      @(posedge clk); #1;
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_k < 0) done_k = k;
      end
      fill = (k == inject_k);
    end
    fill = 1'b0;
  endtask

  task automatic read_cell(input int a, output logic [7:0] v);
    x_pixel = 10'((a % 128) * 8);
    y_pixel = 10'((a / 128) * 16);
    @(posedge clk);
    @(posedge clk); #1;
    v = char_code;
  endtask

  task automatic sweep(input string tag, input bit use_model);
    int bad_range;
    bad_range = 0;
    for (int i = 0; i < CELLS + 2; i++) begin
      if (i >= 2) begin
        chk($sformatf("%s[%0d]", tag, i - 2), char_code, use_model ? exp_fill[i-2] : 8'h20);
        if (char_code < 8'h20 || char_code > 8'h7F) bad_range++;
      end
      if (i < CELLS) begin
        x_pixel = 10'((i % 128) * 8);
        y_pixel = 10'((i / 128) * 16);
      end
      @(posedge clk); #1;
    end
    chk({tag, "_range_bad"}, bad_range, 0);
  endtask

  initial begin
    logic [15:0] s;
    logic [7:0]  v;
    int b, d, k;

    s = 16'hACE1;
    for (int i = 0; i < CELLS; i++) begin
      exp_fill[i] = {1'b0, s[6:0]} | 8'h20;
      s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_char", char_code, 8'h20);
    chk("rst_row", glyph_row, 0);
    chk("rst_col", glyph_col, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    pulse(1'b0, 1'b1);
    run_op(-1, b, d, k);
    chk("clear_busy_len", b, 6144);
    chk("clear_done_cnt", d, 1);
    chk("clear_done_at", k, 6144);
    sweep("clear", 1'b0);

    pulse(1'b1, 1'b0);
    run_op(-1, b, d, k);
    chk("fill_busy_len", b, 6144);
    chk("fill_done_cnt", d, 1);
    chk("fill_done_at", k, 6144);
    read_cell(0, v);
    chk("fill_cell0", v, 8'h61);
    read_cell(1, v);
    chk("fill_cell1", v, 8'h70);
    sweep("fill", 1'b1);

    x_pixel = 10'd0;
    y_pixel = 10'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("align_base", char_code, 8'h61);
    x_pixel = 10'd45;
    y_pixel = 10'd39;
    @(posedge clk); #1;
    chk("align_lat1_char", char_code, 8'h61);
    chk("align_lat1_col", glyph_col, 0);
    @(posedge clk); #1;
    chk("align_char", char_code, exp_fill[2*128+5]);
    chk("align_col", glyph_col, 5);
    chk("align_row", glyph_row, 7);
    y_pixel = 10'd800;
    @(posedge clk);
    @(posedge clk); #1;
    chk("oor_y800", char_code, 8'h20);
    x_pixel = 10'd1023;
    y_pixel = 10'd767;
    @(posedge clk);
    @(posedge clk); #1;
    chk("corner_char", char_code, exp_fill[6143]);
    chk("corner_col", glyph_col, 7);
    chk("corner_row", glyph_row, 15);

    pulse(1'b1, 1'b1);
    run_op(100, b, d, k);
    chk("both_busy_len", b, 6144);
    chk("both_done_cnt", d, 1);
    read_cell(0, v);
    chk("both_cell0", v, 8'h20);
    read_cell(261, v);
    chk("both_cell261", v, 8'h20);

    pulse(1'b1, 1'b0);
    repeat (3000) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_char", char_code, 8'h20);
    reset = 1'b0;
    d = 0;
    b = 0;
    for (int i = 0; i < 6200; i++) begin
      @(posedge clk); #1;
      if (done) d++;
      if (busy) b++;
    end
    chk("midrst_no_done", d, 0);
    chk("midrst_no_busy", b, 0);
    read_cell(2999, v);
    chk("midrst_cell2999", v, exp_fill[2999]);
    read_cell(3001, v);
    chk("midrst_cell3001", v, 8'h20);

    pulse(1'b1, 1'b0);
    run_op(-1, b, d, k);
    chk("refill_done_cnt", d, 1);
    read_cell(0, v);
    chk("refill_cell0", v, 8'h61);
    read_cell(5000, v);
    chk("refill_cell5000", v, exp_fill[5000]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
